partial_store: RTL

Store-side counterpart of the load extractor in the RISC-V core's memory stage. Takes a store request (funct3, byte address, rs2 data) and produces word-aligned memory writes with per-byte write enables, shifting data into the addressed byte lanes. Stores that straddle a word boundary are split into two consecutive writes by a small state machine, or rejected, depending on build configuration. Sits between the execute-stage store path and the DMEM/IO write port.

---
 rtl/partial_store_pkg.sv | 24 ++
 rtl/partial_store_if.sv | 24 ++
 rtl/partial_store_store_lane_gen.sv | 42 ++++
 rtl/partial_store.sv | 135 +++++++++++++
 4 files changed

// File: rtl/partial_store_pkg.sv
// Shared store-path definitions: store funct3 codes, the split-FSM state
// encoding, and the funct3-to-byte-mask helper used by the lane generator.
package partial_store_pkg;

  localparam logic [2:0] FNC_SB = 3'b000;
  localparam logic [2:0] FNC_SH = 3'b001;
  localparam logic [2:0] FNC_SW = 3'b010;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } store_state_t;

  // Unshifted byte mask for a store width; 0000 marks an illegal code.
  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3)
      FNC_SB:  size_mask = 4'b0001;
      FNC_SH:  size_mask = 4'b0011;
      FNC_SW:  size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/partial_store_if.sv
// Store request / memory write-port bundle. master = execute-stage side
// (issues requests, observes writes); slave = the partial_store block.
interface partial_store_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_we;
  logic        store_err;

  modport master (
    output req_valid, req_funct3, req_addr, req_data,
    input  req_ready, mem_valid, mem_addr, mem_din, mem_we, store_err
  );

  modport slave (
    input  req_valid, req_funct3, req_addr, req_data,
    output req_ready, mem_valid, mem_addr, mem_din, mem_we, store_err
  );
endinterface

// File: rtl/partial_store_store_lane_gen.sv
// store_lane_gen: purely combinational lane mapper. Places the sized store
// data and its byte mask into an 8-byte window starting at the word holding
// the address; the upper half of the window is the second word of a split.
// Build option PARTIAL_STORE_MISALIGNED_EN: when undefined, non-natural
// alignment is flagged illegal instead of being split.
module store_lane_gen
  import partial_store_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [63:0] d64,
  output logic [7:0]  m8,
  output logic        illegal,
  output logic        needs_split
);

  logic [3:0]  mask;
  logic [31:0] data_sized;
  logic        bad_code;
`ifndef PARTIAL_STORE_MISALIGNED_EN
  logic        misaligned;
`endif

  // Size the data, shift data and mask into the addressed lanes, classify.
  always_comb begin
    mask        = size_mask(funct3);
    bad_code    = (mask == 4'b0000);
    data_sized  = data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    d64         = {32'h0000_0000, data_sized} << {offset, 3'b000};
    m8          = {4'b0000, mask} << offset;
    needs_split = |m8[7:4];
`ifdef PARTIAL_STORE_MISALIGNED_EN
    illegal     = bad_code;
`else
    misaligned  = ((funct3 == FNC_SH) && offset[0]) ||
                  ((funct3 == FNC_SW) && (offset != 2'b00));
    illegal     = bad_code | misaligned;
`endif
  end

endmodule

// File: rtl/partial_store.sv
// partial_store: turns a store request into word-aligned memory write beats
// with byte enables. All write-port outputs are registered (latency 1).
// Build option PARTIAL_STORE_MISALIGNED_EN: when defined, word-crossing
// stores are split into two beats via a SPLIT state; when undefined they
// are rejected with store_err and req_ready is constant 1.
module partial_store
  import partial_store_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  partial_store_if.slave    bus
);

  // ---- stage p0: request decode (combinational) ----
  logic [63:0] d64_p0;
  logic [7:0]  m8_p0;
  logic        illegal_p0;
  logic        split_p0;
  logic        accept_p0;
  logic [31:0] word_addr_p0;

  store_lane_gen u_lane_gen (
    .funct3      (bus.req_funct3),
    .offset      (bus.req_addr[1:0]),
    .data        (bus.req_data),
    .d64         (d64_p0),
    .m8          (m8_p0),
    .illegal     (illegal_p0),
    .needs_split (split_p0)
  );

  assign word_addr_p0 = {bus.req_addr[31:2], 2'b00};
  assign accept_p0    = bus.req_valid && bus.req_ready;

  // ---- stage p1: registered write port ----
  logic        mem_valid_p1;
  logic [31:0] mem_addr_p1;
  logic [31:0] mem_din_p1;
  logic [3:0]  mem_we_p1;
  logic        store_err_p1;

`ifdef PARTIAL_STORE_MISALIGNED_EN
  store_state_t state;
  logic [31:0]  b2_addr_p1;
  logic [31:0]  b2_din_p1;
  logic [3:0]   b2_we_p1;

  assign bus.req_ready = (state == ST_IDLE);

  // Split FSM with registered beats; the second beat is parked until SPLIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      mem_valid_p1 <= 1'b0;
      mem_addr_p1  <= 32'h0;
      mem_din_p1   <= 32'h0;
      mem_we_p1    <= 4'b0000;
      store_err_p1 <= 1'b0;
    end else begin
      mem_valid_p1 <= 1'b0;
      mem_addr_p1  <= 32'h0;
      mem_din_p1   <= 32'h0;
      mem_we_p1    <= 4'b0000;
      store_err_p1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_p0) begin
            if (illegal_p0) begin
              store_err_p1 <= 1'b1;
            end else begin
              mem_valid_p1 <= 1'b1;
              mem_addr_p1  <= word_addr_p0;
              mem_din_p1   <= d64_p0[31:0];
              mem_we_p1    <= m8_p0[3:0];
              if (split_p0) begin
                state      <= ST_SPLIT;
                b2_addr_p1 <= word_addr_p0 + 32'd4;
                b2_din_p1  <= d64_p0[63:32];
                b2_we_p1   <= m8_p0[7:4];
              end
            end
          end
        end
        ST_SPLIT: begin
          mem_valid_p1 <= 1'b1;
          mem_addr_p1  <= b2_addr_p1;
          mem_din_p1   <= b2_din_p1;
          mem_we_p1    <= b2_we_p1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  // Upper window half can only be non-zero for a misaligned (illegal) store.
  logic unused_hi;
  assign unused_hi     = ^{split_p0, d64_p0[63:32], m8_p0[7:4]};
  assign bus.req_ready = 1'b1;

  // Single-beat write port: every accepted legal store issues one beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid_p1 <= 1'b0;
      mem_addr_p1  <= 32'h0;
      mem_din_p1   <= 32'h0;
      mem_we_p1    <= 4'b0000;
      store_err_p1 <= 1'b0;
    end else begin
      mem_valid_p1 <= 1'b0;
      mem_addr_p1  <= 32'h0;
      mem_din_p1   <= 32'h0;
      mem_we_p1    <= 4'b0000;
      store_err_p1 <= 1'b0;
      if (accept_p0) begin
        if (illegal_p0) begin
          store_err_p1 <= 1'b1;
        end else begin
          mem_valid_p1 <= 1'b1;
          mem_addr_p1  <= word_addr_p0;
          mem_din_p1   <= d64_p0[31:0];
          mem_we_p1    <= m8_p0[3:0];
        end
      end
    end
  end
`endif

  assign bus.mem_valid = mem_valid_p1;
  assign bus.mem_addr  = mem_addr_p1;
  assign bus.mem_din   = mem_din_p1;
  assign bus.mem_we    = mem_we_p1;
  assign bus.store_err = store_err_p1;

endmodule
